seq_mul: RTL and testbench

//  Multi-cycle shift-add multiplier on the register-file read path. Takes two

---
 rtl/seq_mul.sv | 126 ++++++++++++
 tb/tb_seq_mul.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - multi-cycle shift-add multiplier with START/BUSY/DONE handshake
// Optional two's-complement operands when SEQ_MUL_SIGNED_EN is defined.
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RES_HI,
    output logic [WIDTH-1:0] RES_LO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, next_state;
    logic               accept;
    logic               last_iter;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] final_res;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

`ifdef SEQ_MUL_SIGNED_EN
    logic sign;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    assign op_a      = A[WIDTH-1] ? -A : A;
    assign op_b      = B[WIDTH-1] ? -B : B;
    assign final_res = sign ? -product : product;
`else
    assign op_a      = A;
    assign op_b      = B;
    assign final_res = product;
`endif

    assign last_iter = (count == CW'(WIDTH - 1));
    assign sum       = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mcand : '0)};
    // Product as it stands after this iteration's shift.
    assign product   = {sum, mplier[WIDTH-1:1]};

    assign BUSY = (state == S_RUN);
    assign DONE = (state == S_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    next_state = S_RUN;
                    accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    next_state = S_IDLE;
                end else if (last_iter) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (START) begin
                    next_state = S_RUN;
                    accept     = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            RES_HI <= '0;
            RES_LO <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign   <= 1'b0;
`endif
        end else if (accept) begin
            count  <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            acc_hi <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign   <= A[WIDTH-1] ^ B[WIDTH-1];
`endif
        end else if (state == S_RUN && !ABORT) begin
            acc_hi <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            count  <= count + 1'b1;
            if (last_iter) begin
                {RES_HI, RES_LO} <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - directed self-checking bench for seq_mul
module tb_seq_mul;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic       ABORT;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RES_HI;
    logic [7:0] RES_LO;

    int errors = 0;
    int checks = 0;

    seq_mul #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .ABORT  (ABORT),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RES_HI (RES_HI),
        .RES_LO (RES_LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Issue a one-cycle START from a negedge; returns at the negedge after the accepting edge.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BUSY, DONE, RES_HI, RES_LO} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h%h, want all 0", BUSY, DONE, RES_HI, RES_LO);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_basic;
        int busy_bad = 0;
        do_start(8'd13, 8'd11);
        for (int i = 0; i < 8; i++) begin
            if (BUSY !== 1'b1 || DONE !== 1'b0) busy_bad++;
            if (i != 7) @(negedge CLK);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL basic_busy_window: got %0d bad run cycles, want 0", busy_bad);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || {RES_HI, RES_LO} !== 16'h008F) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b res=%h%h, want 1 0 008f", DONE, BUSY, RES_HI, RES_LO);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || {RES_HI, RES_LO} !== 16'h008F) begin
            errors++;
            $display("FAIL basic_after_done: got done=%b busy=%b res=%h%h, want 0 0 008f", DONE, BUSY, RES_HI, RES_LO);
        end
    endtask

    task automatic test_patterns;
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        va[0] = 8'd255; vb[0] = 8'd255;
`ifdef SEQ_MUL_SIGNED_EN
        vp[0] = 16'h0001;
`else
        vp[0] = 16'hFE01;
`endif
        va[1] = 8'd0;   vb[1] = 8'd200; vp[1] = 16'h0000;
        va[2] = 8'd100; vb[2] = 8'd7;   vp[2] = 16'h02BC;
        for (int t = 0; t < 3; t++) begin
            do_start(va[t], vb[t]);
            repeat (8) @(negedge CLK);
            checks++;
            if (DONE !== 1'b1 || {RES_HI, RES_LO} !== vp[t]) begin
                errors++;
                $display("FAIL pattern_%0d: got done=%b res=%h%h, want 1 %h", t, DONE, RES_HI, RES_LO, vp[t]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_start_ignored;
        do_start(8'd10, 8'd20);
        repeat (2) @(negedge CLK);
        A = 8'd2;
        B = 8'd2;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || {RES_HI, RES_LO} !== 16'h00C8) begin
            errors++;
            $display("FAIL start_in_run: got done=%b res=%h%h, want 1 00c8", DONE, RES_HI, RES_LO);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued: got busy=%b done=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_abort;
        int done_seen = 0;
        do_start(8'd7, 8'd9);
        repeat (3) @(negedge CLK);
        ABORT = 1'b1;
        START = 1'b1;
        A = 8'd2;
        B = 8'd2;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || {RES_HI, RES_LO} !== 16'h00C8) begin
            errors++;
            $display("FAIL abort: got busy=%b done=%b res=%h%h, want 0 0 00c8", BUSY, DONE, RES_HI, RES_LO);
        end
        repeat (10) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles, want 0", done_seen);
        end
        ABORT = 1'b1;
        do_start(8'd6, 8'd7);
        ABORT = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b, want 1", BUSY);
        end
        repeat (8) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || {RES_HI, RES_LO} !== 16'h002A) begin
            errors++;
            $display("FAIL start_abort_idle_res: got done=%b res=%h%h, want 1 002a", DONE, RES_HI, RES_LO);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        A = 8'd3;
        B = 8'd4;
        START = 1'b1;
        @(negedge CLK);
        A = 8'd5;
        B = 8'd6;
        repeat (8) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || {RES_HI, RES_LO} !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_first: got done=%b busy=%b res=%h%h, want 1 0 000c", DONE, BUSY, RES_HI, RES_LO);
        end
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1 || {RES_HI, RES_LO} !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_restart: got done=%b busy=%b res=%h%h, want 0 1 000c", DONE, BUSY, RES_HI, RES_LO);
        end
        repeat (8) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || {RES_HI, RES_LO} !== 16'h001E) begin
            errors++;
            $display("FAIL b2b_second: got done=%b res=%h%h, want 1 001e", DONE, RES_HI, RES_LO);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got done=%b busy=%b, want 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_reset_mid_run;
        int active = 0;
        do_start(8'd100, 8'd3);
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, RES_HI, RES_LO} !== 18'h0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b res=%h%h, want all 0", BUSY, DONE, RES_HI, RES_LO);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) active++;
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL reset_discards: got %0d active cycles, want 0", active);
        end
        do_start(8'd13, 8'd11);
        repeat (8) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || {RES_HI, RES_LO} !== 16'h008F) begin
            errors++;
            $display("FAIL after_reset_op: got done=%b res=%h%h, want 1 008f", DONE, RES_HI, RES_LO);
        end
        @(negedge CLK);
    endtask

`ifdef SEQ_MUL_SIGNED_EN
    task automatic test_signed;
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        va[0] = 8'hFD; vb[0] = 8'd5;  vp[0] = 16'hFFF1;
        va[1] = 8'h80; vb[1] = 8'h80; vp[1] = 16'h4000;
        va[2] = 8'h80; vb[2] = 8'd1;  vp[2] = 16'hFF80;
        for (int t = 0; t < 3; t++) begin
            do_start(va[t], vb[t]);
            repeat (8) @(negedge CLK);
            checks++;
            if (DONE !== 1'b1 || {RES_HI, RES_LO} !== vp[t]) begin
                errors++;
                $display("FAIL signed_%0d: got done=%b res=%h%h, want 1 %h", t, DONE, RES_HI, RES_LO, vp[t]);
            end
            @(negedge CLK);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SEQ_MUL_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
